// File: rtl/uart_tx_from_fifo.sv
// UART transmitter fed directly by the read side of an FWFT dual-clock FIFO.
// Pops one 9-bit word at a time and sends it as start bit, 8 data bits LSB first,
// an optional 9th bit, then one or two stop bits.
module uart_tx_from_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned NINE_BIT     = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       enable,
    input  logic [8:0] fifoDo,
    input  logic       fifoEmpty,
    output logic       fifoRdEn,
    output logic       txd,
    output logic       busy,
    output logic       frameDone
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StNinth, StStop} stateT;

    localparam logic [15:0] LastCyc   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] PenultCyc = 16'(CLKS_PER_BIT - 2);
    localparam logic [3:0]  LastStop  = 4'(STOP_BITS - 1);

    stateT       state;
    logic [15:0] cycCnt;
    logic [3:0]  bitCnt;
    logic [8:0]  shiftReg;
    logic        bitEnd;

    assign bitEnd = (cycCnt == LastCyc);

    // Pop strobe; gated by rstN so nothing is consumed while the block is held in reset.
    assign fifoRdEn = rstN & enable & ~fifoEmpty & (state == StIdle);

    // Frame sequencer; txd, busy and frameDone are all registered here.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= StIdle;
            cycCnt    <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            txd       <= 1'b1;
            busy      <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            unique case (state)
                StIdle: begin
                    txd    <= 1'b1;
                    busy   <= 1'b0;
                    cycCnt <= '0;
                    bitCnt <= '0;
                    // FWFT: the word on fifoDo is the one this strobe pops.
                    if (fifoRdEn) begin
                        shiftReg <= fifoDo;
                        state    <= StStart;
                        txd      <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                StStart: begin
                    if (bitEnd) begin
                        cycCnt <= '0;
                        txd    <= shiftReg[0];
                        state  <= StData;
                    end else begin
                        cycCnt <= cycCnt + 16'd1;
                    end
                end
                StData: begin
                    if (bitEnd) begin
                        cycCnt   <= '0;
                        shiftReg <= shiftReg >> 1;
                        if (bitCnt == 4'd7) begin
                            bitCnt <= '0;
                            if (NINE_BIT != 0) begin
                                // After 8 shifts, bit 1 of the pre-shift value is word bit 8.
                                txd   <= shiftReg[1];
                                state <= StNinth;
                            end else begin
                                txd   <= 1'b1;
                                state <= StStop;
                            end
                        end else begin
                            bitCnt <= bitCnt + 4'd1;
                            txd    <= shiftReg[1];
                        end
                    end else begin
                        cycCnt <= cycCnt + 16'd1;
                    end
                end
                StNinth: begin
                    if (bitEnd) begin
                        cycCnt <= '0;
                        bitCnt <= '0;
                        txd    <= 1'b1;
                        state  <= StStop;
                    end else begin
                        cycCnt <= cycCnt + 16'd1;
                    end
                end
                StStop: begin
                    // Raise frameDone one edge early so it is visible in the last stop cycle.
                    if (bitCnt == LastStop && cycCnt == PenultCyc) begin
                        frameDone <= 1'b1;
                    end
                    if (bitEnd) begin
                        cycCnt <= '0;
                        if (bitCnt == LastStop) begin
                            bitCnt <= '0;
                            busy   <= 1'b0;
                            state  <= StIdle;
                        end else begin
                            bitCnt <= bitCnt + 4'd1;
                        end
                    end else begin
                        cycCnt <= cycCnt + 16'd1;
                    end
                end
                default: begin
                    state <= StIdle;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_from_fifo.sv
// Self-checking bench for uart_tx_from_fifo. Two instances: dut0 (8N1) and dut1 (9 data
// bits, 2 stop bits), both at 4 clocks per bit, each fed by a queue-based FWFT FIFO model.
module tb_uart_tx_from_fifo;

    logic       clk = 1'b0;
    logic       rstN;
    logic [1:0] enable;
    logic [8:0] fifoDo [2];
    logic [1:0] fifoEmpty;
    logic [1:0] fifoRdEn;
    logic [1:0] txd;
    logic [1:0] busy;
    logic [1:0] frameDone;

    uart_tx_from_fifo #(.CLKS_PER_BIT(4), .NINE_BIT(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rstN(rstN), .enable(enable[0]), .fifoDo(fifoDo[0]),
        .fifoEmpty(fifoEmpty[0]), .fifoRdEn(fifoRdEn[0]), .txd(txd[0]), .busy(busy[0]),
        .frameDone(frameDone[0])
    );

    uart_tx_from_fifo #(.CLKS_PER_BIT(4), .NINE_BIT(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rstN(rstN), .enable(enable[1]), .fifoDo(fifoDo[1]),
        .fifoEmpty(fifoEmpty[1]), .fifoRdEn(fifoRdEn[1]), .txd(txd[1]), .busy(busy[1]),
        .frameDone(frameDone[1])
    );

    always #5 clk = ~clk;

    logic [8:0]  fifoQ0[$];
    logic [8:0]  fifoQ1[$];
    logic [8:0]  expQ0[$];
    logic [8:0]  expQ1[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          popCnt[2] = '{0, 0};
    int          frameCnt[2] = '{0, 0};
    int          lastPop[2] = '{0, 0};
    int          prevPop[2] = '{0, 0};
    int          lastDone[2] = '{0, 0};
    int          prevDone[2] = '{0, 0};
    int          lastFall[2] = '{0, 0};
    int          txdLowCnt[2] = '{0, 0};
    int          rxCnt[2] = '{0, 0};
    logic        rxBusy[2] = '{1'b0, 1'b0};
    logic [8:0]  rxWord[2] = '{9'h0, 9'h0};
    logic [8:0]  lastExp[2] = '{9'h0, 9'h0};
    logic [63:0] hist[2] = '{64'h0, 64'h0};
    logic [1:0]  rdSeen = 2'b00;
    logic [1:0]  prevTxd = 2'b11;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ideal txd waveform for one frame, oldest cycle in the highest used bit.
    function automatic logic [63:0] expandFrame(input logic [8:0] w, input int nine,
                                                input int stop);
        int          len;
        int          b;
        logic [63:0] r;
        logic        v;
        len = (9 + nine + stop) * 4;
        r   = '0;
        for (int t = 0; t < len; t++) begin
            b = t / 4;
            if (b == 0)                  v = 1'b0;
            else if (b <= 8)             v = w[b-1];
            else if (nine != 0 && b == 9) v = w[8];
            else                         v = 1'b1;
            r[len-1-t] = v;
        end
        return r;
    endfunction

    task automatic refresh();
        fifoEmpty[0] = (fifoQ0.size() == 0);
        fifoEmpty[1] = (fifoQ1.size() == 0);
        // Junk on fifoDo while empty must never be sent.
        fifoDo[0] = fifoEmpty[0] ? 9'($urandom) : fifoQ0[0];
        fifoDo[1] = fifoEmpty[1] ? 9'($urandom) : fifoQ1[0];
    endtask

    task automatic push(input int d, input logic [8:0] w);
        if (d == 0) begin
            fifoQ0.push_back(w);
            expQ0.push_back({1'b0, w[7:0]});
        end else begin
            fifoQ1.push_back(w);
            expQ1.push_back(w);
        end
        refresh();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitFrames(input int d, input int target, input int budget);
        int i = 0;
        while (frameCnt[d] < target && i < budget) begin
            tick(1);
            i++;
        end
        check("waitFrames", 64'(frameCnt[d] >= target), 1);
    endtask

    task automatic waitPops(input int d, input int target, input int budget);
        int i = 0;
        while (popCnt[d] < target && i < budget) begin
            tick(1);
            i++;
        end
        check("waitPops", 64'(popCnt[d] >= target), 1);
    endtask

    // FIFO model: the pop strobe seen at the negedge takes effect just after the posedge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdSeen[0] && fifoQ0.size() > 0) void'(fifoQ0.pop_front());
            if (rdSeen[1] && fifoQ1.size() > 0) void'(fifoQ1.pop_front());
            refresh();
        end
    end

    // Monitor, UART receiver and scoreboard, sampled mid-cycle.
    initial begin
        int b;
        int len;
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                len = (9 + d + d + 1) * 4;
                check("rdEnLegal", 64'(fifoRdEn[d] & (fifoEmpty[d] | busy[d])), 0);
                rdSeen[d] = fifoRdEn[d];
                hist[d] = {hist[d][62:0], txd[d]};
                if (!txd[d]) txdLowCnt[d]++;
                if (prevTxd[d] && !txd[d]) lastFall[d] = cyc;
                prevTxd[d] = txd[d];
                if (fifoRdEn[d]) begin
                    popCnt[d]++;
                    prevPop[d] = lastPop[d];
                    lastPop[d] = cyc;
                end
                if (!rstN) begin
                    rxBusy[d] = 1'b0;
                end else if (!rxBusy[d]) begin
                    if (!txd[d]) begin
                        rxBusy[d] = 1'b1;
                        rxCnt[d]  = 0;
                        rxWord[d] = '0;
                    end
                end else begin
                    rxCnt[d]++;
                    if (rxCnt[d] % 4 == 2) begin
                        b = rxCnt[d] / 4;
                        if (b == 0) begin
                            check("rxStart", 64'(txd[d]), 0);
                        end else if (b <= 8) begin
                            rxWord[d][b-1] = txd[d];
                        end else if (d == 1 && b == 9) begin
                            rxWord[d][8] = txd[d];
                        end else begin
                            check("rxStop", 64'(txd[d]), 1);
                            if (b == 8 + d + d + 1) begin
                                if (d == 0) begin
                                    check("rxExpPending", 64'(expQ0.size() > 0), 1);
                                    if (expQ0.size() > 0) lastExp[d] = expQ0.pop_front();
                                end else begin
                                    check("rxExpPending", 64'(expQ1.size() > 0), 1);
                                    if (expQ1.size() > 0) lastExp[d] = expQ1.pop_front();
                                end
                                check("rxWord", 64'(rxWord[d]), 64'(lastExp[d]));
                                rxBusy[d] = 1'b0;
                            end
                        end
                    end
                end
                if (frameDone[d]) begin
                    frameCnt[d]++;
                    prevDone[d] = lastDone[d];
                    lastDone[d] = cyc;
                    check("frameLen", 64'(cyc - lastPop[d]), 64'(len));
                    check("frameWave", hist[d] & ((64'd1 << len) - 64'd1),
                          expandFrame(lastExp[d], d, d + 1));
                end
            end
        end
    end

    initial begin
        int p;
        int f;
        rstN   = 1'b0;
        enable = 2'b00;
        refresh();
        tick(2);
        check("rstTxd", 64'(txd), 64'(2'b11));
        check("rstBusy", 64'(busy), 0);
        check("rstFrameDone", 64'(frameDone), 0);
        check("rstRdEn", 64'(fifoRdEn), 0);
        rstN = 1'b1;
        tick(1);

        // Empty FIFO with enable high: line stays idle, no pops.
        enable = 2'b11;
        tick(100);
        check("idlePops0", 64'(popCnt[0]), 0);
        check("idlePops1", 64'(popCnt[1]), 0);
        check("idleTxdLow0", 64'(txdLowCnt[0]), 0);
        check("idleTxdLow1", 64'(txdLowCnt[1]), 0);
        check("idleBusy", 64'(busy), 0);

        // Single 8N1 frame.
        push(0, 9'h0A5);
        waitFrames(0, 1, 200);
        check("onePop", 64'(popCnt[0]), 1);

        // 9-bit, two stop bits.
        push(1, 9'h1A5);
        waitFrames(1, 1, 200);
        check("onePop9", 64'(popCnt[1]), 1);

        // Back-to-back frames.
        f = frameCnt[0];
        push(0, 9'h055);
        push(0, 9'h0FF);
        waitFrames(0, f + 2, 300);
        check("popGap", 64'(lastPop[0] - prevPop[0]), 41);
        check("startAfterStop", 64'(lastFall[0] - prevDone[0]), 2);

        // enable dropped mid-frame.
        p = popCnt[0];
        f = frameCnt[0];
        push(0, 9'h011);
        push(0, 9'h022);
        push(0, 9'h033);
        waitPops(0, p + 1, 50);
        tick(10);
        enable[0] = 1'b0;
        waitFrames(0, f + 1, 100);
        tick(60);
        check("holdPops", 64'(popCnt[0]), 64'(p + 1));
        check("holdBusy", 64'(busy[0]), 0);
        check("holdTxd", 64'(txd[0]), 1);
        enable[0] = 1'b1;
        waitFrames(0, f + 3, 300);
        check("resumePops", 64'(popCnt[0]), 64'(p + 3));

        // Reset during data bit 3 of a frame.
        p = popCnt[0];
        f = frameCnt[0];
        push(0, 9'h0F0);
        push(0, 9'h03C);
        waitPops(0, p + 1, 50);
        tick(17);
        #2;
        check("preRstTxd", 64'(txd[0]), 0);
        check("preRstBusy", 64'(busy[0]), 1);
        rstN = 1'b0;
        #1;
        check("abortTxd", 64'(txd[0]), 1);
        check("abortBusy", 64'(busy[0]), 0);
        check("abortDone", 64'(frameDone[0]), 0);
        void'(expQ0.pop_front());
        tick(2);
        rstN = 1'b1;
        check("abortNoFrame", 64'(frameCnt[0]), 64'(f));
        waitFrames(0, f + 1, 200);
        check("afterRstPops", 64'(popCnt[0]), 64'(p + 2));

        tick(10);
        check("expQ0Drained", 64'(expQ0.size()), 0);
        check("expQ1Drained", 64'(expQ1.size()), 0);
        check("fifoQ0Drained", 64'(fifoQ0.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
